// File: rtl/cov_mon_pkg.sv
// Shared types and helpers for the coverage stall monitor.
package cov_mon_pkg;

  // Monitor FSM states.
  typedef enum logic [1:0] {
    RUN  = 2'd0,
    FIRE = 2'd1,
    HOLD = 2'd2
  } mon_state_e;

  // Working width for threshold arithmetic; wide enough for any sane CNT_W+COV_W.
  localparam int unsigned THR_W = 128;
  typedef logic [THR_W-1:0] thr_t;

  // base_wait*((cov_val>>shift)+1), wrapped at prod_w bits, then saturated to cnt_w bits.
  function automatic thr_t sat_thresh(input thr_t        base_wait,
                                      input thr_t        cov_val,
                                      input int unsigned shift,
                                      input int unsigned prod_w,
                                      input int unsigned cnt_w);
    thr_t prod;
    thr_t lim;
    prod = base_wait * ((cov_val >> shift) + thr_t'(1));
    prod = prod & ((thr_t'(1) << prod_w) - thr_t'(1));
    lim  = (thr_t'(1) << cnt_w) - thr_t'(1);
    return (prod > lim) ? lim : prod;
  endfunction

endpackage

// File: rtl/cov_stall_chan.sv
// One coverage channel: tracks the last coverage value and how long it has been stuck.
module cov_stall_chan import cov_mon_pkg::*; #(
  parameter int unsigned COV_W       = 30,
  parameter int unsigned CNT_W       = 32,
  parameter int unsigned BASE_WAIT   = 1000,
  parameter int unsigned SCALE_SHIFT = 19
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic             clr_i,
  input  logic [COV_W-1:0] cov_i,
  output logic             stall_c_o
);

  logic [COV_W-1:0] pre_cov_q, pre_cov_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] thresh_c;
  logic             changed_c;

  // Next-state for the previous-coverage register and the saturating stall counter.
  always_comb begin
    changed_c = en_i && (cov_i != pre_cov_q);
    pre_cov_d = changed_c ? cov_i : pre_cov_q;
    count_d   = count_q;
    if (clr_i || changed_c) begin
      count_d = '0;
    end else if (en_i && (count_q != '1)) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  // Channel state registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pre_cov_q <= '0;
      count_q   <= '0;
    end else begin
      pre_cov_q <= pre_cov_d;
      count_q   <= count_d;
    end
  end

  // Higher coverage buys a proportionally longer wait before declaring a stall.
  assign thresh_c  = CNT_W'(sat_thresh(thr_t'(BASE_WAIT), thr_t'(pre_cov_q), SCALE_SHIFT,
                                       CNT_W + COV_W, CNT_W));
  assign stall_c_o = (count_q >= thresh_c);

endmodule

// File: rtl/cov_stall_monitor.sv
// Coverage stall monitor: raises an interrupt when coverage stops moving or a global watchdog expires.
module cov_stall_monitor import cov_mon_pkg::*; #(
  parameter int unsigned NCH         = 2,
  parameter int unsigned COV_W       = 30,
  parameter int unsigned CNT_W       = 32,
  parameter int unsigned BASE_WAIT   = 1000,
  parameter int unsigned SCALE_SHIFT = 19,
  parameter int unsigned WDOG_LIMIT  = 50000,
  parameter int unsigned HOLDOFF     = 16,
  parameter int unsigned PULSE_MODE  = 0
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 en,
  input  logic [NCH*COV_W-1:0] cov,
  input  logic [63:0]          tohost,
  input  logic                 int_ack,
  output logic                 interrupt,
  output logic [NCH:0]         cause
);

  localparam int unsigned HO_W  = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
  localparam int unsigned CMP_W = (CNT_W > 32) ? CNT_W : 32;

  mon_state_e       state_q;
  logic             interrupt_q;
  logic [NCH:0]     cause_q;
  logic [HO_W-1:0]  hold_cnt_q;
  logic [CNT_W-1:0] wdog_q, wdog_d;

  logic [NCH-1:0]   stall_c;
  logic             wd_hit_c;
  logic [NCH:0]     trig_c;
  logic             done_c;
  logic             leave_c;
  logic             clr_c;
  logic             tohost_unused;

  assign tohost_unused = ^tohost[63:1];

  // Completion marker and FIRE exit both restart every stall measurement.
  assign done_c   = tohost[0];
  assign leave_c  = (state_q == FIRE) && ((PULSE_MODE != 0) || int_ack || done_c);
  assign clr_c    = done_c || leave_c;
  assign wd_hit_c = (CMP_W'(wdog_q) >= CMP_W'(WDOG_LIMIT));
  assign trig_c   = {wd_hit_c, stall_c};

  // Per-channel stall detectors.
  for (genvar g = 0; g < NCH; g++) begin : g_chan
    cov_stall_chan #(
      .COV_W       (COV_W),
      .CNT_W       (CNT_W),
      .BASE_WAIT   (BASE_WAIT),
      .SCALE_SHIFT (SCALE_SHIFT)
    ) u_chan (
      .clk_i     (clock),
      .rst_i     (reset),
      .en_i      (en),
      .clr_i     (clr_c),
      .cov_i     (cov[g*COV_W +: COV_W]),
      .stall_c_o (stall_c[g])
    );
  end

  // Saturating global watchdog next-state.
  always_comb begin
    wdog_d = wdog_q;
    if (clr_c) begin
      wdog_d = '0;
    end else if (en && (wdog_q != '1)) begin
      wdog_d = wdog_q + CNT_W'(1);
    end
  end

  // Watchdog register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wdog_q <= '0;
    end else begin
      wdog_q <= wdog_d;
    end
  end

  // Interrupt FSM with registered interrupt and cause.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= RUN;
      interrupt_q <= 1'b0;
      cause_q     <= '0;
      hold_cnt_q  <= '0;
    end else begin
      case (state_q)
        RUN: begin
          hold_cnt_q <= '0;
          if ((|trig_c) && !done_c) begin
            state_q     <= FIRE;
            interrupt_q <= 1'b1;
            cause_q     <= trig_c;
          end
        end
        FIRE: begin
          if (leave_c) begin
            state_q     <= HOLD;
            interrupt_q <= 1'b0;
            cause_q     <= '0;
            hold_cnt_q  <= '0;
          end
        end
        HOLD: begin
          if (32'(hold_cnt_q) + 32'd1 >= HOLDOFF) begin
            state_q <= RUN;
          end else begin
            hold_cnt_q <= hold_cnt_q + HO_W'(1);
          end
        end
        default: begin
          state_q     <= RUN;
          interrupt_q <= 1'b0;
          cause_q     <= '0;
          hold_cnt_q  <= '0;
        end
      endcase
    end
  end

  assign interrupt = interrupt_q;
  assign cause     = cause_q;

endmodule

// File: tb/tb_cov_stall_monitor.sv
// Randomized and directed bench for cov_stall_monitor, checked against a cycle-level reference model.
module tb_cov_stall_monitor;

  localparam int unsigned NCH         = 2;
  localparam int unsigned COV_W       = 30;
  localparam int unsigned CNT_W       = 32;
  localparam int unsigned BASE_WAIT   = 8;
  localparam int unsigned SCALE_SHIFT = 4;
  localparam int unsigned WDOG_LIMIT  = 100;
  localparam int unsigned HOLDOFF     = 4;
  localparam int          PH_RUN      = 0;
  localparam int          PH_FIRE     = 1;
  localparam int          PH_HOLD     = 2;
  localparam longint      MAXC        = (longint'(1) << CNT_W) - 1;

  logic                 clock = 1'b0;
  logic                 reset;
  logic                 en;
  logic [NCH*COV_W-1:0] cov;
  logic [63:0]          tohost;
  logic                 int_ack;
  logic                 intr_l, intr_p, intr_z;
  logic [NCH:0]         cause_l, cause_p, cause_z;
  logic                 dut_int   [3];
  logic [NCH:0]         dut_cause [3];

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state; instance 0 level/holdoff 4, 1 pulse/holdoff 4, 2 level/holdoff 0.
  longint       m_cnt [3][NCH];
  longint       m_pre [3][NCH];
  longint       m_wd  [3];
  int           m_ph  [3];
  int           m_hl  [3];
  logic         m_int [3];
  logic [NCH:0] m_cause [3];

  always #5 clock = ~clock;

  cov_stall_monitor #(.NCH(NCH), .COV_W(COV_W), .CNT_W(CNT_W), .BASE_WAIT(BASE_WAIT),
    .SCALE_SHIFT(SCALE_SHIFT), .WDOG_LIMIT(WDOG_LIMIT), .HOLDOFF(HOLDOFF), .PULSE_MODE(0)) u_lvl (
    .clock(clock), .reset(reset), .en(en), .cov(cov), .tohost(tohost), .int_ack(int_ack),
    .interrupt(intr_l), .cause(cause_l));

  cov_stall_monitor #(.NCH(NCH), .COV_W(COV_W), .CNT_W(CNT_W), .BASE_WAIT(BASE_WAIT),
    .SCALE_SHIFT(SCALE_SHIFT), .WDOG_LIMIT(WDOG_LIMIT), .HOLDOFF(HOLDOFF), .PULSE_MODE(1)) u_pls (
    .clock(clock), .reset(reset), .en(en), .cov(cov), .tohost(tohost), .int_ack(int_ack),
    .interrupt(intr_p), .cause(cause_p));

  cov_stall_monitor #(.NCH(NCH), .COV_W(COV_W), .CNT_W(CNT_W), .BASE_WAIT(BASE_WAIT),
    .SCALE_SHIFT(SCALE_SHIFT), .WDOG_LIMIT(WDOG_LIMIT), .HOLDOFF(0), .PULSE_MODE(0)) u_h0 (
    .clock(clock), .reset(reset), .en(en), .cov(cov), .tohost(tohost), .int_ack(int_ack),
    .interrupt(intr_z), .cause(cause_z));

  assign dut_int[0] = intr_l;  assign dut_cause[0] = cause_l;
  assign dut_int[1] = intr_p;  assign dut_cause[1] = cause_p;
  assign dut_int[2] = intr_z;  assign dut_cause[2] = cause_z;

  function automatic longint thr(input longint pre);
    longint t;
    t = longint'(BASE_WAIT) * ((pre >> SCALE_SHIFT) + 1);
    return (t > MAXC) ? MAXC : t;
  endfunction

  task automatic model_reset();
    for (int p = 0; p < 3; p++) begin
      for (int c = 0; c < NCH; c++) begin
        m_cnt[p][c] = 0;
        m_pre[p][c] = 0;
      end
      m_wd[p] = 0; m_ph[p] = PH_RUN; m_hl[p] = 0; m_int[p] = 1'b0; m_cause[p] = '0;
    end
  endtask

  // One rising edge of behaviour, evaluated from the inputs present at that edge.
  task automatic model_step();
    for (int p = 0; p < 3; p++) begin
      logic [NCH:0] trig;
      bit           done, leave, clr, chg;
      longint       v;
      done = tohost[0];
      for (int c = 0; c < NCH; c++) trig[c] = (m_cnt[p][c] >= thr(m_pre[p][c]));
      trig[NCH] = (m_wd[p] >= longint'(WDOG_LIMIT));
      leave = (m_ph[p] == PH_FIRE) && ((p == 1) || int_ack || done);
      clr   = done || leave;
      for (int c = 0; c < NCH; c++) begin
        v   = longint'(cov[c*COV_W +: COV_W]);
        chg = en && (v != m_pre[p][c]);
        if (chg) m_pre[p][c] = v;
        if (clr || chg) m_cnt[p][c] = 0;
        else if (en && m_cnt[p][c] < MAXC) m_cnt[p][c]++;
      end
      if (clr) m_wd[p] = 0;
      else if (en && m_wd[p] < MAXC) m_wd[p]++;
      case (m_ph[p])
        PH_RUN:  if (trig != 0 && !done) begin
                   m_ph[p] = PH_FIRE; m_int[p] = 1'b1; m_cause[p] = trig;
                 end
        PH_FIRE: if (leave) begin
                   m_ph[p] = PH_HOLD; m_int[p] = 1'b0; m_cause[p] = '0;
                   m_hl[p] = (p == 2) ? 1 : int'(HOLDOFF);
                 end
        default: begin
                   m_hl[p]--;
                   if (m_hl[p] <= 0) m_ph[p] = PH_RUN;
                 end
      endcase
    end
  endtask

  always @(posedge clock) if (reset !== 1'b1) model_step();

  task automatic do_reset(input logic [COV_W-1:0] c0, input logic [COV_W-1:0] c1);
    reset = 1'b1; model_reset();
    en = 1'b1; tohost = '0; int_ack = 1'b0;
    cov[0 +: COV_W] = c0; cov[COV_W +: COV_W] = c1;
    @(posedge clock); #1;
    reset = 1'b0;
  endtask

  task automatic step(input bit inc0, input bit inc1);
    @(posedge clock); #1;
    if (inc0) cov[0 +: COV_W]     = cov[0 +: COV_W] + COV_W'(1);
    if (inc1) cov[COV_W +: COV_W] = cov[COV_W +: COV_W] + COV_W'(1);
  endtask

  task automatic test_reset();
    reset = 1'b1; model_reset();
    en = 1'b1; tohost = '0; int_ack = 1'b0; cov = '0;
    #2;
    for (int p = 0; p < 3; p++) begin
      n_checks++;
      if (dut_int[p] !== 1'b0 || dut_cause[p] !== '0) begin
        n_errors++;
        $display("FAIL reset_state inst %0d: int=%b cause=%b want 0/000", p, dut_int[p], dut_cause[p]);
      end
    end
    @(posedge clock); #1;
  endtask

  task automatic test_stall_basic();
    int k; bit got;
    do_reset(30'd0, 30'd1);
    k = 0; got = 0;
    while (!got && k < 200) begin step(0, 1); k++; if (intr_l === 1'b1) got = 1; end
    n_checks++;
    if (k != 9) begin n_errors++; $display("FAIL stall_basic_latency: got %0d edges want 9", k); end
    n_checks++;
    if (cause_l !== 3'b001) begin n_errors++; $display("FAIL stall_basic_cause: got %b want 001", cause_l); end
  endtask

  task automatic test_ack_refire();
    int k; bit got;
    int_ack = 1'b1; step(0, 1); int_ack = 1'b0;
    n_checks++;
    if (intr_l !== 1'b0 || cause_l !== '0) begin
      n_errors++; $display("FAIL ack_clear: int=%b cause=%b want 0/000", intr_l, cause_l);
    end
    k = 0; got = 0;
    while (!got && k < 200) begin step(0, 1); k++; if (intr_l === 1'b1) got = 1; end
    n_checks++;
    if (k != 9) begin n_errors++; $display("FAIL ack_refire_latency: got %0d edges want 9", k); end
    n_checks++;
    if (cause_l !== 3'b001) begin n_errors++; $display("FAIL ack_refire_cause: got %b want 001", cause_l); end
  endtask

  task automatic test_pulse();
    int highs; logic prev;
    highs = 0; prev = intr_p;
    for (int i = 0; i < 40; i++) begin
      step(0, 1);
      if (intr_p === 1'b1) highs++;
      n_checks++;
      if (intr_p === 1'b1 && prev === 1'b1) begin
        n_errors++; $display("FAIL pulse_width cycle %0d: int high two cycles in a row", i);
      end
      n_checks++;
      if (intr_p !== m_int[1] || cause_p !== m_cause[1]) begin
        n_errors++;
        $display("FAIL pulse_model cycle %0d: int=%b cause=%b want %b/%b", i, intr_p, cause_p, m_int[1], m_cause[1]);
      end
      prev = intr_p;
    end
    n_checks++;
    if (highs != 4) begin n_errors++; $display("FAIL pulse_count: got %0d want 4", highs); end
  endtask

  task automatic test_scaled();
    int k; bit got;
    do_reset(30'h20, 30'd1);
    k = 0; got = 0;
    while (!got && k < 200) begin step(0, 1); k++; if (intr_l === 1'b1) got = 1; end
    n_checks++;
    if (k != 26) begin n_errors++; $display("FAIL scaled_latency: got %0d edges want 26", k); end
    n_checks++;
    if (cause_l !== 3'b001) begin n_errors++; $display("FAIL scaled_cause: got %b want 001", cause_l); end
  endtask

  task automatic test_wdog();
    int k; bit got;
    do_reset(30'd1, 30'd5);
    k = 0; got = 0;
    while (!got && k < 300) begin step(1, 1); k++; if (intr_l === 1'b1) got = 1; end
    n_checks++;
    if (k != 101) begin n_errors++; $display("FAIL wdog_latency: got %0d edges want 101", k); end
    n_checks++;
    if (cause_l !== 3'b100) begin n_errors++; $display("FAIL wdog_cause: got %b want 100", cause_l); end
  endtask

  task automatic test_tohost();
    int k; bit got;
    do_reset(30'd0, 30'd1);
    for (int i = 0; i < 6; i++) step(0, 1);
    tohost = 64'd1; step(0, 1); tohost = '0;
    n_checks++;
    if (intr_l !== 1'b0) begin n_errors++; $display("FAIL tohost_early: int=%b want 0", intr_l); end
    k = 0; got = 0;
    while (!got && k < 200) begin step(0, 1); k++; if (intr_l === 1'b1) got = 1; end
    n_checks++;
    if (k != 9) begin n_errors++; $display("FAIL tohost_latency: got %0d edges want 9", k); end
    // Completion in the same cycle as a live trigger must swallow it.
    do_reset(30'd0, 30'd1);
    for (int i = 0; i < 8; i++) step(0, 1);
    tohost = 64'd1; step(0, 1); tohost = '0;
    n_checks++;
    if (intr_l !== 1'b0) begin n_errors++; $display("FAIL tohost_suppress: int=%b want 0", intr_l); end
    k = 0; got = 0;
    while (!got && k < 200) begin step(0, 1); k++; if (intr_l === 1'b1) got = 1; end
    n_checks++;
    if (k != 9) begin n_errors++; $display("FAIL tohost_suppress_latency: got %0d edges want 9", k); end
  endtask

  task automatic test_en();
    int k; bit got;
    do_reset(30'd0, 30'd1);
    for (int i = 0; i < 5; i++) step(0, 1);
    en = 1'b0;
    for (int i = 0; i < 20; i++) step(0, 1);
    n_checks++;
    if (intr_l !== 1'b0) begin n_errors++; $display("FAIL en_hold: int=%b want 0", intr_l); end
    en = 1'b1;
    k = 0; got = 0;
    while (!got && k < 200) begin step(0, 1); k++; if (intr_l === 1'b1) got = 1; end
    n_checks++;
    if (k != 4) begin n_errors++; $display("FAIL en_resume_latency: got %0d edges want 4", k); end
    en = 1'b0; int_ack = 1'b1; step(0, 0); int_ack = 1'b0;
    n_checks++;
    if (intr_l !== 1'b0) begin n_errors++; $display("FAIL en_ack: int=%b want 0", intr_l); end
    en = 1'b1;
  endtask

  task automatic test_async_reset();
    do_reset(30'd0, 30'd1);
    for (int i = 0; i < 9; i++) step(0, 1);
    n_checks++;
    if (intr_l !== 1'b1) begin n_errors++; $display("FAIL async_setup_fire: int=%b want 1", intr_l); end
    #2; reset = 1'b1; model_reset(); #1;
    n_checks++;
    if (intr_l !== 1'b0 || cause_l !== '0) begin
      n_errors++; $display("FAIL async_reset_fire: int=%b cause=%b want 0/000", intr_l, cause_l);
    end
    @(posedge clock); #1; reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step(1, 1);
      n_checks++;
      if (intr_l !== 1'b0) begin n_errors++; $display("FAIL async_residual_fire cycle %0d: int=%b want 0", i, intr_l); end
    end
    // Same again, but hit reset while in HOLD.
    do_reset(30'd0, 30'd1);
    for (int i = 0; i < 9; i++) step(0, 1);
    int_ack = 1'b1; step(0, 1); int_ack = 1'b0;
    step(0, 1);
    #2; reset = 1'b1; model_reset(); #1;
    n_checks++;
    if (intr_l !== 1'b0 || cause_l !== '0) begin
      n_errors++; $display("FAIL async_reset_hold: int=%b cause=%b want 0/000", intr_l, cause_l);
    end
    @(posedge clock); #1; reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step(1, 1);
      n_checks++;
      if (intr_l !== 1'b0) begin n_errors++; $display("FAIL async_residual_hold cycle %0d: int=%b want 0", i, intr_l); end
    end
  endtask

  task automatic test_random();
    do_reset(COV_W'($urandom_range(0, 63)), COV_W'($urandom_range(0, 63)));
    for (int i = 0; i < 3000; i++) begin
      en      = ($urandom_range(0, 9) != 0);
      tohost  = ($urandom_range(0, 199) == 0) ? 64'd1 : 64'd0;
      int_ack = ($urandom_range(0, 7) == 0);
      for (int c = 0; c < NCH; c++)
        if ($urandom_range(0, 15) == 0) cov[c*COV_W +: COV_W] = COV_W'($urandom_range(0, 63));
      @(posedge clock); #1;
      for (int p = 0; p < 3; p++) begin
        n_checks++;
        if (dut_int[p] !== m_int[p] || dut_cause[p] !== m_cause[p]) begin
          n_errors++;
          $display("FAIL random inst %0d cycle %0d: int=%b cause=%b want %b/%b",
                   p, i, dut_int[p], dut_cause[p], m_int[p], m_cause[p]);
        end
      end
    end
    tohost = '0; int_ack = 1'b0; en = 1'b1;
  endtask

  initial begin
    test_reset();
    test_stall_basic();
    test_ack_refire();
    test_pulse();
    test_scaled();
    test_wdog();
    test_tohost();
    test_en();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
